bias_add_bank: RTL and testbench

Parametrised, loadable bias stage that sits between the adder-tree outputs of a conv layer and its requantise/activation logic. It replaces the per-layer constant bias banks with one block. The block holds N_GROUPS × N_adder_tree biases that are written at run time, and adds the bias for the current channel group to each lane of an accumulator beat. Each sum is saturated to DATA_W bits and optionally passed through ReLU. A 2-stage pipeline with valid/ready backpressure carries the result.

---
 rtl/bias_pkg.sv | 37 +++
 rtl/bias_lane_sat.sv | 29 ++
 rtl/bias_add_bank.sv | 150 +++++++++++++++
 tb/tb_bias_add_bank.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bias_pkg
// Description : Shared definitions for the bias_add_bank slice.
//               DATA_W          - two's-complement width of accumulator, bias
//                                 and result
//               N_LANES_DEF     - default number of lanes per beat
//               lane_t          - one signed lane
//               lane_vec_t      - packed lane array at the default lane count
//               sat_add()       - sign-extend, add and clamp to DATA_W bits
// Revision    : 1.0 - initial release
// ============================================================================
package bias_pkg;

    localparam int DATA_W      = 18;
    localparam int N_LANES_DEF = 16;

    typedef logic signed [DATA_W-1:0] lane_t;
    typedef lane_t [N_LANES_DEF-1:0]  lane_vec_t;

    localparam lane_t c_sat_max = {1'b0, {(DATA_W-1){1'b1}}};
    localparam lane_t c_sat_min = {1'b1, {(DATA_W-1){1'b0}}};

    // The (DATA_W+1)-bit sum overflowed exactly when its top two bits
    // disagree; the top bit then gives the direction of the overflow.
    function automatic lane_t sat_add(input lane_t a, input lane_t b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            sat_add = s[DATA_W] ? c_sat_min : c_sat_max;
        end else begin
            sat_add = s[DATA_W-1:0];
        end
    endfunction

endpackage : bias_pkg
`default_nettype wire

// File: rtl/bias_lane_sat.sv
`default_nettype none
// ============================================================================
// Module      : bias_lane_sat
// Description : Combinational per-lane bias add with saturation and optional
//               ReLU.
//   acc      in  DATA_W  accumulator lane
//   bias     in  DATA_W  bias for this lane
//   relu_en  in  1       clamp negative results to zero
//   res      out DATA_W  saturated (and optionally rectified) result
// Revision    : 1.0 - initial release
// ============================================================================
module bias_lane_sat
    import bias_pkg::*;
(
    input  lane_t acc,
    input  lane_t bias,
    input  logic  relu_en,
    output lane_t res
);

    lane_t w_sat;

    always_comb begin
        w_sat = sat_add(acc, bias);
        res   = (relu_en && w_sat[DATA_W-1]) ? '0 : w_sat;
    end

endmodule : bias_lane_sat
`default_nettype wire

// File: rtl/bias_add_bank.sv
`default_nettype none
// ============================================================================
// Module      : bias_add_bank
// Description : Run-time loadable bias bank for a conv layer. Adds the bias
//               row of the current channel group to every lane of an
//               accumulator beat, saturates, optionally applies ReLU, and
//               delivers the result through a 2-stage valid/ready pipeline.
//   clk        in   1                 clock, rising edge
//   rst        in   1                 synchronous active-high reset
//   ld_valid   in   1                 bias write strobe
//   ld_group   in   GRP_W             target group (>= N_GROUPS ignored)
//   ld_lane    in   LANE_W            target lane
//   ld_data    in   DATA_W            bias value
//   relu_en    in   1                 clamp negative results to zero
//   in_valid   in   1                 accumulator beat valid
//   in_ready   out  1                 beat accepted when in_valid & in_ready
//   in_first   in   1                 beat is group 0 of a new pixel
//   in_data    in   N*DATA_W          packed accumulator lanes
//   out_valid  out  1                 result valid
//   out_ready  in   1                 downstream accept
//   out_data   out  N*DATA_W          packed results
//   out_group  out  GRP_W             group of out_data
// Revision    : 1.0 - initial release
// ============================================================================
module bias_add_bank
    import bias_pkg::*;
#(
    parameter int N_adder_tree = N_LANES_DEF,
    parameter int N_GROUPS     = 4,
    parameter int GRP_W        = $clog2(N_GROUPS),
    parameter int LANE_W       = $clog2(N_adder_tree)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_valid,
    input  logic [GRP_W-1:0]                 ld_group,
    input  logic [LANE_W-1:0]                ld_lane,
    input  logic [DATA_W-1:0]                ld_data,
    input  logic                             relu_en,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_first,
    input  logic [N_adder_tree*DATA_W-1:0]   in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_adder_tree*DATA_W-1:0]   out_data,
    output logic [GRP_W-1:0]                 out_group
);

    localparam logic [GRP_W:0]   c_n_groups = (GRP_W+1)'(N_GROUPS);
    localparam logic [GRP_W-1:0] c_last_grp = GRP_W'(N_GROUPS-1);

    lane_t                       r_bias [N_GROUPS][N_adder_tree];
    logic [GRP_W-1:0]            r_grp_ptr;

    logic                        r_s1_valid;
    logic [GRP_W-1:0]            r_s1_group;
    lane_t                       r_s1_acc  [N_adder_tree];
    lane_t                       r_s1_bias [N_adder_tree];

    logic                        r_out_valid;
    logic [N_adder_tree*DATA_W-1:0] r_out_data;
    logic [GRP_W-1:0]            r_out_group;

    lane_t                       w_sum [N_adder_tree];
    logic                        w_advance;
    logic                        w_accept;
    logic                        w_ld_ok;
    logic [GRP_W-1:0]            w_used_grp;
    logic [GRP_W-1:0]            w_next_grp;

    // Whole pipeline moves as one: no skid buffer, so a stalled output
    // freezes stage 1 as well.
    always_comb begin
        w_advance  = !r_out_valid || out_ready;
        w_accept   = in_valid && w_advance;
        w_used_grp = in_first ? '0 : r_grp_ptr;
        w_next_grp = (w_used_grp == c_last_grp) ? '0 : w_used_grp + 1'b1;
        w_ld_ok    = ld_valid && ({1'b0, ld_group} < c_n_groups);
    end

    // Held high through reset; anything accepted then is discarded by reset.
    assign in_ready  = rst || w_advance;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_group = r_out_group;

    // Bias memory. Stage 1 reads it in the accepting cycle, so a write to the
    // same entry in that cycle is only seen by later beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < N_GROUPS; g++) begin
                for (int k = 0; k < N_adder_tree; k++) begin
                    r_bias[g][k] <= '0;
                end
            end
        end else if (w_ld_ok) begin
            r_bias[ld_group][ld_lane] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grp_ptr   <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_group  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_group <= '0;
            for (int k = 0; k < N_adder_tree; k++) begin
                r_s1_acc[k]  <= '0;
                r_s1_bias[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_grp_ptr <= w_next_grp;
            end
            if (w_advance) begin
                r_s1_valid  <= w_accept;
                r_out_valid <= r_s1_valid;
                if (w_accept) begin
                    r_s1_group <= w_used_grp;
                    for (int k = 0; k < N_adder_tree; k++) begin
                        r_s1_acc[k]  <= in_data[k*DATA_W +: DATA_W];
                        r_s1_bias[k] <= r_bias[w_used_grp][k];
                    end
                end
                if (r_s1_valid) begin
                    r_out_group <= r_s1_group;
                    for (int k = 0; k < N_adder_tree; k++) begin
                        r_out_data[k*DATA_W +: DATA_W] <= w_sum[k];
                    end
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
            bias_lane_sat u_lane (
                .acc     (r_s1_acc[k]),
                .bias    (r_s1_bias[k]),
                .relu_en (relu_en),
                .res     (w_sum[k])
            );
        end
    endgenerate

endmodule : bias_add_bank
`default_nettype wire

// File: tb/tb_bias_add_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_bias_add_bank
// Description : Self-checking bench for bias_add_bank. Expected results are
//               computed from a bench-side bias/group model when a beat is
//               accepted, queued, and compared as outputs are delivered.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_add_bank;

    localparam int N  = 16;
    localparam int DW = 18;
    localparam int NG = 4;
    localparam int GW = 2;
    localparam int LW = 4;
    localparam int W  = N * DW;
    localparam int SMAX = (1 << (DW-1)) - 1;
    localparam int SMIN = -(1 << (DW-1));

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic [GW-1:0] ld_group;
    logic [LW-1:0] ld_lane;
    logic [DW-1:0] ld_data;
    logic          relu_en;
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [GW-1:0] out_group;

    bias_add_bank #(.N_adder_tree(N), .N_GROUPS(NG)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_group(ld_group), .ld_lane(ld_lane), .ld_data(ld_data),
        .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_group(out_group)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [GW-1:0] grp;
        logic [W-1:0]  data;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t                 sb[$];
    exp_t                 mon_e;
    int                   n_checks = 0;
    int                   n_err    = 0;
    int                   cyc      = 0;
    logic signed [DW-1:0] m_bias [NG][N];
    logic [GW-1:0]        m_grp;

    // Bias model: same write semantics as the memory, updated at the edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int g = 0; g < NG; g++)
                for (int k = 0; k < N; k++)
                    m_bias[g][k] <= '0;
        end else if (ld_valid && ld_group < NG) begin
            m_bias[ld_group][ld_lane] <= ld_data;
        end
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] acc,
                                           input logic [GW-1:0] g, input bit relu);
        logic [W-1:0] r;
        int a, b, s;
        r = '0;
        for (int k = 0; k < N; k++) begin
            a = $signed(acc[k*DW +: DW]);
            b = m_bias[g][k];
            s = a + b;
            if (s > SMAX) s = SMAX;
            if (s < SMIN) s = SMIN;
            if (relu && s < 0) s = 0;
            r[k*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    // Scoreboard consumer: every delivered result must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got data=%h group=%0d, required no output",
                         out_data, out_group);
            end else begin
                mon_e = sb.pop_front();
                if (out_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL out_data: got %h required %h", out_data, mon_e.data);
                end
                n_checks++;
                if (out_group !== mon_e.grp) begin
                    n_err++;
                    $display("FAIL out_group: got %0d required %0d", out_group, mon_e.grp);
                end
                if (mon_e.chk_lat) begin
                    n_checks++;
                    if (cyc - mon_e.acc_cyc != 1) begin
                        n_err++;
                        $display("FAIL latency: output %0d edges after accept edge, required 1 (2 cycles)",
                                 cyc - mon_e.acc_cyc);
                    end
                end
            end
        end
    end

    task automatic send_beat(input bit first, input logic [W-1:0] data, input bit chk_lat);
        exp_t ent;
        logic [GW-1:0] used;
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        in_first = first;
        in_data  = data;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc         = 1;
                used        = first ? '0 : m_grp;
                ent.grp     = used;
                ent.data    = model(data, used, relu_en);
                ent.acc_cyc = cyc + 1;
                ent.chk_lat = chk_lat;
                sb.push_back(ent);
                m_grp = (used == GW'(NG-1)) ? '0 : used + 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding results, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_load(input int g, input int l, input int v);
        ld_valid = 1'b1;
        ld_group = GW'(g);
        ld_lane  = LW'(l);
        ld_data  = DW'(v);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        ld_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_grp = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %h required 0", out_data); end
        n_checks++;
        if (out_group !== '0) begin n_err++; $display("FAIL rst_out_group: got %0d required 0", out_group); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        rst   = 1'b0;
        m_grp = '0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst_idle: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_load_add();
        logic [W-1:0] want;
        do_reset();
        do_load(1, 3, 100);
        send_beat(1'b1, fill(5), 1'b1);
        send_beat(1'b0, fill(5), 1'b1);
        drain();
        want = fill(5);
        want[3*DW +: DW] = DW'(105);
        n_checks++;
        if (out_data !== want || out_group !== 2'd1) begin
            n_err++;
            $display("FAIL load_add_beat1: got %h grp %0d required %h grp 1", out_data, out_group, want);
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] v;
        do_reset();
        relu_en = 1'b0;
        do_load(0, 0, 131000);
        do_load(0, 1, -131000);
        v = '0;
        v[0 +: DW]  = DW'(1000);
        v[DW +: DW] = DW'(-1000);
        send_beat(1'b1, v, 1'b1);
        drain();
        n_checks++;
        if (out_data[0 +: DW] !== 18'h1FFFF || out_data[DW +: DW] !== 18'h20000) begin
            n_err++;
            $display("FAIL sat_clamp: got lane0=%h lane1=%h required 1ffff/20000",
                     out_data[0 +: DW], out_data[DW +: DW]);
        end
        relu_en = 1'b1;
        send_beat(1'b1, v, 1'b1);
        drain();
        n_checks++;
        if (out_data[0 +: DW] !== 18'h1FFFF || out_data[DW +: DW] !== 18'h00000) begin
            n_err++;
            $display("FAIL sat_relu: got lane0=%h lane1=%h required 1ffff/00000",
                     out_data[0 +: DW], out_data[DW +: DW]);
        end
        relu_en = 1'b0;
    endtask

    task automatic test_group_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) send_beat(1'b0, fill(i + 1), 1'b1);
        drain();
        n_checks++;
        if (out_group !== 2'd0) begin n_err++; $display("FAIL wrap_group: got %0d required 0", out_group); end
        send_beat(1'b1, fill(20), 1'b1);
        send_beat(1'b1, fill(21), 1'b1);
        drain();
        n_checks++;
        if (out_group !== 2'd0) begin n_err++; $display("FAIL restart_group: got %0d required 0", out_group); end
    endtask

    task automatic test_collision();
        do_reset();
        ld_valid = 1'b1;
        ld_group = '0;
        ld_lane  = '0;
        ld_data  = DW'(7);
        send_beat(1'b1, '0, 1'b1);
        ld_valid = 1'b0;
        drain();
        n_checks++;
        if (out_data[0 +: DW] !== 18'd0) begin
            n_err++; $display("FAIL collision_old: got %0d required 0", out_data[0 +: DW]);
        end
        send_beat(1'b1, '0, 1'b1);
        drain();
        n_checks++;
        if (out_data[0 +: DW] !== 18'd7) begin
            n_err++; $display("FAIL collision_new: got %0d required 7", out_data[0 +: DW]);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] snap;
        logic [W-1:0] v;
        do_reset();
        do_load(2, 5, -40);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(i * 100 + k);
                    send_beat(i == 0, v, 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                snap = out_data;
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_entry: got out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
                end
                repeat (2) begin
                    @(posedge clk);
                    @(negedge clk);
                    n_checks++;
                    if (out_data !== snap || out_valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL stall_hold: got %h valid %b required %h valid 1", out_data, out_valid, snap);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        do_load(0, 2, 50);
        out_ready = 1'b0;
        send_beat(1'b1, fill(3), 1'b0);
        send_beat(1'b0, fill(4), 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst       = 1'b0;
        m_grp     = '0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
        end
        n_checks++;
        if (out_data !== '0 || out_group !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: got %h grp %0d required 0 grp 0", out_data, out_group);
        end
        @(posedge clk); #1;
        send_beat(1'b1, fill(9), 1'b1);
        drain();
        n_checks++;
        if (out_data !== fill(9)) begin
            n_err++; $display("FAIL midrst_bias_cleared: got %h required %h", out_data, fill(9));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_group  = '0;
        ld_lane   = '0;
        ld_data   = '0;
        relu_en   = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        m_grp     = '0;
        test_reset();
        test_load_add();
        test_saturation();
        test_group_wrap();
        test_collision();
        test_backpressure();
        test_reset_midstream();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_bias_add_bank
`default_nettype wire
